alu_serial_seq: RTL and testbench

- Sequencer that runs one WIDTH-bit ALU operation over the shared 1-bit ALU slice, one bit per cycle, LSB first.
- The slice contains the 1-bit logic unit (sel 00 AND, 01 OR, 10 XOR, 11 NOT A) and a 1-bit full adder.
- This block holds the operands, drives the slice bit by bit, carries the carry between bits, assembles the result and returns it with a valid/ready handshake.
- It sits between the register/issue logic and the 1-bit slice.

---
 rtl/alu_serial_seq.sv | 142 ++++++++++++++
 tb/tb_alu_serial_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: runs one WIDTH-bit ALU op over a shared 1-bit slice, LSB first.
// Defining ALU_SEQ_FLAGS_EN adds registered zero_o/ovf_o result flags.
module alu_serial_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic             slice_a_o,
    output logic             slice_b_o,
    output logic [1:0]       slice_sel_o,
    output logic             slice_arith_o,
    output logic             slice_cin_o,
    input  logic             slice_res_i,
    input  logic             slice_cout_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             err_o
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic             zero_o,
    output logic             ovf_o
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, res_next;
    logic [2:0] op_q, op_d;
    logic carry_q, carry_d, cout_q, cout_d, err_q, err_d;
    logic run, arith, sub, last, illegal;
`ifdef ALU_SEQ_FLAGS_EN
    logic zero_q, zero_d, ovf_q, ovf_d;
    assign zero_o = zero_q;
    assign ovf_o  = ovf_q;
`endif
    assign run      = state_q == RUN;
    assign arith    = op_q[2];
    assign sub      = op_q == 3'b101;
    assign last     = cnt_q == CNT_W'(WIDTH-1);
    assign illegal  = op_i[2] & op_i[1];
    assign res_next = {slice_res_i, res_q[WIDTH-1:1]};
    assign req_ready_o   = state_q == IDLE;
    assign rsp_valid_o   = state_q == DONE;
    assign result_o      = res_q;
    assign cout_o        = cout_q;
    assign err_o         = err_q;
    // Slice is driven only while bits are being processed; idle otherwise.
    assign slice_a_o     = run & a_q[0];
    assign slice_b_o     = run & (b_q[0] ^ sub);
    assign slice_sel_o   = (run && !arith) ? op_q[1:0] : 2'b00;
    assign slice_arith_o = run & arith;
    assign slice_cin_o   = run & carry_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        res_d   = res_q;
        cout_d  = cout_q;
        err_d   = err_q;
`ifdef ALU_SEQ_FLAGS_EN
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (req_valid_i) begin
                a_d     = a_i;
                b_d     = b_i;
                op_d    = op_i;
                cnt_d   = '0;
                carry_d = op_i == 3'b101;
                res_d   = '0;
                cout_d  = 1'b0;
                err_d   = illegal;
`ifdef ALU_SEQ_FLAGS_EN
                zero_d  = illegal;
                ovf_d   = 1'b0;
`endif
                state_d = illegal ? DONE : RUN;
            end
            RUN: begin
                res_d   = res_next;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = arith & slice_cout_i;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    cout_d  = arith & slice_cout_i;
`ifdef ALU_SEQ_FLAGS_EN
                    zero_d  = res_next == '0;
                    // carry_q is the carry into the MSB on the last bit
                    ovf_d   = arith & (carry_q ^ slice_cout_i);
`endif
                end
            end
            DONE: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: table, hand-written and random checks of alu_serial_seq with a 1-bit slice model.
module tb_alu_serial_seq;
    localparam int W = 32;
    typedef struct {
        logic [W-1:0] a, b;
        logic [2:0]   op;
        logic [W-1:0] res;
        logic         cout, err, zero, ovf;
    } vec_t;

    logic clk_i = 0, rst_ni = 0, req_valid_i = 0, rsp_ready_i = 0;
    logic [W-1:0] a_i = 0, b_i = 0, result_o;
    logic [2:0] op_i = 0;
    logic req_ready_o, slice_a_o, slice_b_o, slice_arith_o, slice_cin_o;
    logic [1:0] slice_sel_o;
    logic slice_res_i, slice_cout_i, rsp_valid_o, cout_o, err_o;
    logic zero_o, ovf_o;
    int n_cmp = 0, n_bad = 0;

    always #5 clk_i = ~clk_i;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .a_i(a_i), .b_i(b_i), .op_i(op_i), .slice_a_o(slice_a_o), .slice_b_o(slice_b_o),
        .slice_sel_o(slice_sel_o), .slice_arith_o(slice_arith_o), .slice_cin_o(slice_cin_o),
        .slice_res_i(slice_res_i), .slice_cout_i(slice_cout_i), .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i), .result_o(result_o), .cout_o(cout_o), .err_o(err_o)
`ifdef ALU_SEQ_FLAGS_EN
        , .zero_o(zero_o), .ovf_o(ovf_o)
`endif
    );
`ifndef ALU_SEQ_FLAGS_EN
    assign zero_o = 1'b0;
    assign ovf_o  = 1'b0;
`endif

    // The shared 1-bit slice: logic unit plus full adder
    always_comb begin
        slice_res_i  = slice_arith_o ? (slice_a_o ^ slice_b_o ^ slice_cin_o) :
                       slice_sel_o == 2'd0 ? (slice_a_o & slice_b_o) :
                       slice_sel_o == 2'd1 ? (slice_a_o | slice_b_o) :
                       slice_sel_o == 2'd2 ? (slice_a_o ^ slice_b_o) : ~slice_a_o;
        slice_cout_i = slice_arith_o & ((slice_a_o & slice_b_o) | (slice_a_o & slice_cin_o) |
                                        (slice_b_o & slice_cin_o));
    end

    function automatic vec_t ref_model(input logic [W-1:0] a, b, input logic [2:0] op);
        vec_t e;
        logic [W:0] s;
        e = '{a: a, b: b, op: op, res: '0, cout: 0, err: 0, zero: 0, ovf: 0};
        case (op)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: e.res = a ^ b;
            3'd3: e.res = ~a;
            3'd4: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0]; e.cout = s[W];
                e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'd5: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                e.res = s[W-1:0]; e.cout = s[W];
                e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            default: e.err = 1;
        endcase
        e.zero = e.res == 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, b, input logic [2:0] op);
        int guard = 0;
        @(negedge clk_i);
        a_i = a; b_i = b; op_i = op; req_valid_i = 1;
        while (!req_ready_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 200) check("issue_timeout", 0, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 0;
        a_i = $urandom; b_i = $urandom; op_i = 3'($urandom);
    endtask

    // Starts on the negedge right after the accept edge; leaves DONE pending with rsp_ready_i=1.
    task automatic collect(input vec_t e, input int hold);
        int lat = 0;
        bit sel_ok = 1, hold_ok = 1;
        logic [2:0] op = e.op;
        rsp_ready_i = (hold == 0);
        while (!rsp_valid_o && lat < W + 5) begin
            if (slice_sel_o != (op[2] ? 2'b00 : op[1:0]) || slice_arith_o != op[2]) sel_ok = 0;
            @(negedge clk_i);
            lat++;
        end
        check("latency", lat, e.err ? 0 : W);
        check("slice_sel_run", sel_ok, 1);
        check("slice_idle_done", {slice_a_o, slice_b_o, slice_sel_o, slice_arith_o, slice_cin_o}, 0);
        check("result", result_o, e.res);
        check("cout", cout_o, e.cout);
        check("err", err_o, e.err);
`ifdef ALU_SEQ_FLAGS_EN
        check("zero", zero_o, e.zero);
        check("ovf", ovf_o, e.ovf);
`endif
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                req_valid_i = 1;
                @(negedge clk_i);
                if (!rsp_valid_o || result_o !== e.res || cout_o !== e.cout || err_o !== e.err || req_ready_o)
                    hold_ok = 0;
            end
            check("hold_stable", hold_ok, 1);
            req_valid_i = 0;
            rsp_ready_i = 1;
        end
    endtask

    vec_t tbl[10];
    vec_t e;
    bit seen;

    initial begin
        tbl[0] = '{a: 32'hFFFFFFFF, b: 32'h00000001, op: 3'd4, res: 32'h00000000, cout: 1, err: 0, zero: 1, ovf: 0};
        tbl[1] = '{a: 32'h00000005, b: 32'h00000003, op: 3'd4, res: 32'h00000008, cout: 0, err: 0, zero: 0, ovf: 0};
        tbl[2] = '{a: 32'h00000003, b: 32'h00000005, op: 3'd5, res: 32'hFFFFFFFE, cout: 0, err: 0, zero: 0, ovf: 0};
        tbl[3] = '{a: 32'h80000000, b: 32'h00000001, op: 3'd5, res: 32'h7FFFFFFF, cout: 1, err: 0, zero: 0, ovf: 1};
        tbl[4] = '{a: 32'hF0F0A5A5, b: 32'hFF00F00F, op: 3'd0, res: 32'hF000A005, cout: 0, err: 0, zero: 0, ovf: 0};
        tbl[5] = '{a: 32'hF0F0A5A5, b: 32'hFF00F00F, op: 3'd1, res: 32'hFFF0F5AF, cout: 0, err: 0, zero: 0, ovf: 0};
        tbl[6] = '{a: 32'hF0F0A5A5, b: 32'hFF00F00F, op: 3'd2, res: 32'h0FF055AA, cout: 0, err: 0, zero: 0, ovf: 0};
        tbl[7] = '{a: 32'hF0F0A5A5, b: 32'hFF00F00F, op: 3'd3, res: 32'h0F0F5A5A, cout: 0, err: 0, zero: 0, ovf: 0};
        tbl[8] = '{a: 32'h12345678, b: 32'h9ABCDEF0, op: 3'd6, res: 32'h00000000, cout: 0, err: 1, zero: 1, ovf: 0};
        tbl[9] = '{a: 32'h7FFFFFFF, b: 32'h00000001, op: 3'd4, res: 32'h80000000, cout: 0, err: 0, zero: 0, ovf: 1};

        repeat (2) @(negedge clk_i);
        check("rst_req_ready", req_ready_o, 1);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_result", {cout_o, err_o, result_o}, 0);
        check("rst_slice", {slice_a_o, slice_b_o, slice_sel_o, slice_arith_o, slice_cin_o}, 0);
        rst_ni = 1;

        issue(32'h5, 32'h3, 3'd4);
        repeat (9) @(negedge clk_i);
        rst_ni = 0;
        @(negedge clk_i);
        rst_ni = 1;
        check("abort_req_ready", req_ready_o, 1);
        check("abort_rsp_valid", rsp_valid_o, 0);
        check("abort_result", result_o, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen = 1;
        end
        check("abort_no_rsp", seen, 0);

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].op);
            collect(tbl[i], 0);
        end

        e = ref_model(32'hA5A5A5A5, 32'h0F0F0F0F, 3'd2);
        issue(e.a, e.b, e.op);
        collect(e, 5);
        req_valid_i = 1; a_i = 32'd1; b_i = 32'd2; op_i = 3'd4;
        @(negedge clk_i);
        check("b2b_idle_ready", req_ready_o, 1);
        check("b2b_idle_no_rsp", rsp_valid_o, 0);
        @(negedge clk_i);
        req_valid_i = 0;
        check("b2b_accepted", req_ready_o, 0);
        e = ref_model(32'd1, 32'd2, 3'd4);
        collect(e, 0);

        e = ref_model(32'hDEADBEEF, 32'h1, 3'd7);
        issue(e.a, e.b, e.op);
        collect(e, 3);

        for (int i = 0; i < 40; i++) begin
            e = ref_model($urandom, $urandom, 3'($urandom_range(0, 7)));
            issue(e.a, e.b, e.op);
            collect(e, $urandom_range(0, 2));
        end

        @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
